// File: rtl/vtg_pkg.sv
// Shared timing constants and polarity type for the video timing generator.
package vtg_pkg;

    typedef enum logic {
        POL_LOW  = 1'b0,
        POL_HIGH = 1'b1
    } pol_e;

    // 640x480 @ 60 Hz, 25.175 MHz pixel clock
    localparam int VGA_H_RES  = 640;
    localparam int VGA_H_FP   = 16;
    localparam int VGA_H_SYNC = 96;
    localparam int VGA_H_BP   = 48;
    localparam int VGA_V_RES  = 480;
    localparam int VGA_V_FP   = 10;
    localparam int VGA_V_SYNC = 2;
    localparam int VGA_V_BP   = 33;

endpackage

// File: rtl/vtg_axis.sv
// One timing axis: modulo-TOT position counter with active and sync window decode.
module vtg_axis #(
    parameter int RES  = 640,
    parameter int FP   = 16,
    parameter int SYNC = 96,
    parameter int BP   = 48,
    parameter int CW   = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          step,
    output logic [CW-1:0] cnt,
    output logic          last,
    output logic          act,
    output logic          sync
);

    localparam int TOT = RES + FP + SYNC + BP;
    localparam logic [CW-1:0] CNT_LAST = CW'(TOT - 1);
    localparam logic [CW-1:0] ACT_END  = CW'(RES);
    localparam logic [CW-1:0] SYNC_LO  = CW'(RES + FP);
    localparam logic [CW-1:0] SYNC_HI  = CW'(RES + FP + SYNC);

    assign last = (cnt == CNT_LAST);
    assign act  = (cnt < ACT_END);
    assign sync = (cnt >= SYNC_LO) && (cnt < SYNC_HI);

    // Wrap on the decoded last position so the period is TOT, not 2^CW
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (step) begin
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator with registered, mutually aligned outputs.
// Define VTG_FRAME_CNT_EN to build the o_frame counter; otherwise it is tied to 0.
module video_timing_gen
    import vtg_pkg::*;
#(
    parameter int   H_RES  = VGA_H_RES,
    parameter int   H_FP   = VGA_H_FP,
    parameter int   H_SYNC = VGA_H_SYNC,
    parameter int   H_BP   = VGA_H_BP,
    parameter int   V_RES  = VGA_V_RES,
    parameter int   V_FP   = VGA_V_FP,
    parameter int   V_SYNC = VGA_V_SYNC,
    parameter int   V_BP   = VGA_V_BP,
    parameter pol_e HS_POL = POL_LOW,
    parameter pol_e VS_POL = POL_LOW,
    parameter int   CW     = 12,
    parameter int   FW     = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_ce,
    output logic [CW-1:0] o_x,
    output logic [CW-1:0] o_y,
    output logic          o_de,
    output logic          o_hsync,
    output logic          o_vsync,
    output logic          o_sol,
    output logic          o_sof,
    output logic [FW-1:0] o_frame
);

    localparam logic HS_IDLE = (HS_POL == POL_HIGH) ? 1'b0 : 1'b1;
    localparam logic VS_IDLE = (VS_POL == POL_HIGH) ? 1'b0 : 1'b1;

    logic [CW-1:0] h;
    logic [CW-1:0] v;
    logic          h_last;
    logic          v_last;
    logic          h_act;
    logic          v_act;
    logic          h_sync;
    logic          v_sync;

    vtg_axis #(
        .RES (H_RES),
        .FP  (H_FP),
        .SYNC(H_SYNC),
        .BP  (H_BP),
        .CW  (CW)
    ) u_h (
        .clk (i_clk),
        .rst (i_rst),
        .step(i_ce),
        .cnt (h),
        .last(h_last),
        .act (h_act),
        .sync(h_sync)
    );

    vtg_axis #(
        .RES (V_RES),
        .FP  (V_FP),
        .SYNC(V_SYNC),
        .BP  (V_BP),
        .CW  (CW)
    ) u_v (
        .clk (i_clk),
        .rst (i_rst),
        .step(i_ce & h_last),
        .cnt (v),
        .last(v_last),
        .act (v_act),
        .sync(v_sync)
    );

    // Strobes drop on any edge without a load so they stay one clock wide
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_x     <= '0;
            o_y     <= '0;
            o_de    <= 1'b0;
            o_hsync <= HS_IDLE;
            o_vsync <= VS_IDLE;
            o_sol   <= 1'b0;
            o_sof   <= 1'b0;
        end else begin
            o_sol <= 1'b0;
            o_sof <= 1'b0;
            if (i_ce) begin
                o_x     <= h;
                o_y     <= v;
                o_de    <= h_act & v_act;
                o_hsync <= h_sync ? ~HS_IDLE : HS_IDLE;
                o_vsync <= v_sync ? ~VS_IDLE : VS_IDLE;
                o_sol   <= (h == '0);
                o_sof   <= (h == '0) && (v == '0);
            end
        end
    end

`ifdef VTG_FRAME_CNT_EN
    localparam logic [CW-1:0] H_LAST = CW'(H_RES + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_RES + V_FP + V_SYNC + V_BP - 1);

    logic [FW-1:0] frame;

    // Step on the load that leaves the last pixel, i.e. alongside o_sof
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            frame <= '0;
        end else if (i_ce && (o_x == H_LAST) && (o_y == V_LAST)) begin
            frame <= frame + 1'b1;
        end
    end

    assign o_frame = frame;
`else
    assign o_frame = '0;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: default 640x480 instance plus a tiny raster instance.
module tb_video_timing_gen;
    import vtg_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Default-parameter instance
    logic        rst_a, ce_a;
    logic [11:0] xa, ya;
    logic        de_a, hs_a, vs_a, sol_a, sof_a;
    logic [15:0] fr_a;

    video_timing_gen u_a (
        .i_clk  (clk),
        .i_rst  (rst_a),
        .i_ce   (ce_a),
        .o_x    (xa),
        .o_y    (ya),
        .o_de   (de_a),
        .o_hsync(hs_a),
        .o_vsync(vs_a),
        .o_sol  (sol_a),
        .o_sof  (sof_a),
        .o_frame(fr_a)
    );

    // Small raster: 14 x 8 totals, hsync active-high
    localparam int HT = 14;
    localparam int VT = 8;
    localparam int HR = 8;
    localparam int VR = 4;

    logic        rst_b, ce_b;
    logic [11:0] xb, yb;
    logic        de_b, hs_b, vs_b, sol_b, sof_b;
    logic [1:0]  fr_b;

    video_timing_gen #(
        .H_RES (8),
        .H_FP  (2),
        .H_SYNC(3),
        .H_BP  (1),
        .V_RES (4),
        .V_FP  (1),
        .V_SYNC(2),
        .V_BP  (1),
        .HS_POL(POL_HIGH),
        .VS_POL(POL_LOW),
        .CW    (12),
        .FW    (2)
    ) u_b (
        .i_clk  (clk),
        .i_rst  (rst_b),
        .i_ce   (ce_b),
        .o_x    (xb),
        .o_y    (yb),
        .o_de   (de_b),
        .o_hsync(hs_b),
        .o_vsync(vs_b),
        .o_sol  (sol_b),
        .o_sof  (sof_b),
        .o_frame(fr_b)
    );

    logic [30:0] act_b;
    assign act_b = {xb, yb, de_b, hs_b, vs_b, sol_b, sof_b, fr_b};

    int k_b = 0;
    bit en_b = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [30:0] pk(input int x, input int y, input bit de,
                                       input bit hs, input bit vs, input bit sol,
                                       input bit sof, input int f);
        return {12'(x), 12'(y), de, hs, vs, sol, sof, 2'(f)};
    endfunction

    // k = enabled loads since reset; load k shows raster position k-1
    function automatic logic [30:0] model_b(input int k, input bit en);
        int idx, x, y, f;
        bit de, hs, vs, sol, sof;
        if (k == 0) return pk(0, 0, 0, 0, 1, 0, 0, 0);
        idx = k - 1;
        x = idx % HT;
        y = (idx / HT) % VT;
        f = (idx / (HT * VT)) % 4;
`ifndef VTG_FRAME_CNT_EN
        f = 0;
`endif
        de  = (x < HR) && (y < VR);
        hs  = (x >= 10) && (x < 13);
        vs  = !((y >= 5) && (y < 7));
        sol = en && (x == 0);
        sof = sol && (y == 0);
        return pk(x, y, de, hs, vs, sol, sof, f);
    endfunction

    task automatic step_b(input logic r, input logic c);
        @(negedge clk);
        rst_b = r;
        ce_b  = c;
        @(posedge clk);
        if (r) k_b = 0;
        else if (c) k_b++;
        en_b = c && !r;
        #1;
    endtask

    task automatic step_a(input logic r, input logic c);
        @(negedge clk);
        rst_a = r;
        ce_a  = c;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic        ce;
        logic [30:0] exp;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int lowcnt, decnt, fall1, fall2, solcnt, sofcnt, nf, x0, w;
        bit prev;

        rst_a = 1'b1; ce_a = 1'b0;
        rst_b = 1'b1; ce_b = 1'b0;

        tbl[0] = '{1'b1, 1'b1, pk(0, 0, 0, 0, 1, 0, 0, 0)};
        tbl[1] = '{1'b0, 1'b0, pk(0, 0, 0, 0, 1, 0, 0, 0)};
        tbl[2] = '{1'b0, 1'b1, pk(0, 0, 1, 0, 1, 1, 1, 0)};
        tbl[3] = '{1'b0, 1'b0, pk(0, 0, 1, 0, 1, 0, 0, 0)};
        tbl[4] = '{1'b0, 1'b1, pk(1, 0, 1, 0, 1, 0, 0, 0)};
        tbl[5] = '{1'b0, 1'b1, pk(2, 0, 1, 0, 1, 0, 0, 0)};
        tbl[6] = '{1'b1, 1'b1, pk(0, 0, 0, 0, 1, 0, 0, 0)};
        tbl[7] = '{1'b0, 1'b1, pk(0, 0, 1, 0, 1, 1, 1, 0)};
        tbl[8] = '{1'b0, 1'b1, pk(1, 0, 1, 0, 1, 0, 0, 0)};

        for (int i = 0; i < 9; i++) begin
            step_b(tbl[i].rst, tbl[i].ce);
            chk($sformatf("tbl%0d", i), act_b, tbl[i].exp);
        end

        // Random enable and occasional mid-frame reset against the model
        for (int i = 0; i < 3000; i++) begin
            step_b(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0));
            if (act_b !== model_b(k_b, en_b)) begin
                chk($sformatf("rand%0d", i), act_b, model_b(k_b, en_b));
            end else begin
                n_cmp++;
            end
        end

        // hsync on the small raster: high for x=10..12, period 14
        step_b(1'b1, 1'b1);
        fall1 = -1; fall2 = -1; w = 0; prev = 1'b0; x0 = -1;
        for (int c = 0; c < 40; c++) begin
            step_b(1'b0, 1'b1);
            if (hs_b && !prev) begin
                if (fall1 < 0) begin fall1 = c; x0 = int'(xb); end
                else if (fall2 < 0) fall2 = c;
            end
            if (hs_b && fall2 < 0) w++;
            prev = hs_b;
        end
        chk("b_hs_x", 64'(x0), 64'd10);
        chk("b_hs_w", 64'(w), 64'd3);
        chk("b_hs_per", 64'(fall2 - fall1), 64'd14);

        // Frame counter across five start-of-frame strobes
        step_b(1'b1, 1'b1);
        nf = 0;
        for (int c = 0; c < 5 * HT * VT + 20 && nf < 5; c++) begin
            step_b(1'b0, 1'b1);
            if (sof_b) begin
`ifdef VTG_FRAME_CNT_EN
                chk($sformatf("frame%0d", nf), 64'(fr_b), 64'(nf % 4));
`else
                chk($sformatf("frame%0d", nf), 64'(fr_b), 64'd0);
`endif
                nf++;
            end
        end
        chk("frame_strobes", 64'(nf), 64'd5);

        // Default raster, continuous enable
        step_a(1'b1, 1'b1);
        chk("a_reset", {xa, ya, de_a, hs_a, vs_a, sol_a, sof_a, fr_a},
            {12'd0, 12'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0});
        step_a(1'b0, 1'b1);
        chk("a_first", {xa, ya, de_a, sol_a, sof_a}, {12'd0, 12'd0, 1'b1, 1'b1, 1'b1});
        lowcnt = 0; decnt = 0; fall1 = -1; fall2 = -1; prev = hs_a;
        for (int c = 1; c <= 1600; c++) begin
            step_a(1'b0, 1'b1);
            if (!hs_a) lowcnt++;
            if (de_a) decnt++;
            if (prev && !hs_a) begin
                if (fall1 < 0) begin
                    fall1 = c;
                    chk("a_hs_x", 64'(xa), 64'd656);
                end else if (fall2 < 0) fall2 = c;
            end
            prev = hs_a;
        end
        chk("a_hs_low", 64'(lowcnt), 64'd192);
        chk("a_de_cnt", 64'(decnt), 64'd1280);
        chk("a_line_per", 64'(fall2 - fall1), 64'd800);
        chk("a_y_end", {xa, ya, vs_a}, {12'd0, 12'd2, 1'b1});

        // Enable every other clock: periods double, strobes stay one clock
        step_a(1'b1, 1'b1);
        lowcnt = 0; fall1 = -1; fall2 = -1; solcnt = 0; sofcnt = 0; prev = hs_a;
        for (int c = 0; c < 3200; c++) begin
            step_a(1'b0, (c % 2 == 0));
            if (!hs_a) lowcnt++;
            if (sol_a) solcnt++;
            if (sof_a) sofcnt++;
            if (prev && !hs_a) begin
                if (fall1 < 0) fall1 = c;
                else if (fall2 < 0) fall2 = c;
            end
            prev = hs_a;
        end
        chk("h2_hs_low", 64'(lowcnt), 64'd384);
        chk("h2_line_per", 64'(fall2 - fall1), 64'd1600);
        chk("h2_sol_cnt", 64'(solcnt), 64'd2);
        chk("h2_sof_cnt", 64'(sofcnt), 64'd1);

        // Reset mid-line at x=300
        step_a(1'b1, 1'b1);
        w = 0;
        while (xa != 12'd300 && w < 400) begin
            step_a(1'b0, 1'b1);
            w++;
        end
        chk("mid_reach", 64'(xa), 64'd300);
        step_a(1'b1, 1'b1);
        chk("mid_rst", {xa, ya, de_a, hs_a, vs_a, sol_a, sof_a},
            {12'd0, 12'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
        step_a(1'b0, 1'b0);
        chk("mid_hold", {xa, ya, de_a, sol_a, sof_a}, {12'd0, 12'd0, 1'b0, 1'b0, 1'b0});
        step_a(1'b0, 1'b1);
        chk("mid_load", {xa, ya, de_a, sol_a, sof_a}, {12'd0, 12'd0, 1'b1, 1'b1, 1'b1});
        step_a(1'b0, 1'b1);
        chk("mid_next", {xa, ya, sol_a, sof_a}, {12'd1, 12'd0, 1'b0, 1'b0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
